// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle MEM-stage data memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Byte-offset bits dropped to form the word index.
  localparam int WORD_OFS = 2;

  function automatic logic in_range(input logic [29:0] idx, input int unsigned depth);
    return ({2'b00, idx} < depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data memory: synchronous write, full clear on reset,
// asynchronous read of a single word.
module dmem_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage update: reset wipes every word, otherwise a single-word write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[widx] <= wdata;
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory for the MEM stage: stalls the pipeline for LATENCY
// cycles, then completes the access and pulses done (with err on bad accesses).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam int AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW       = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int CNT_INIT = (LATENCY > 1) ? (LATENCY - 2) : 0;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CNT_INIT);

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be >= 1");
    end
    if (DATA_W != 32) begin : g_bad_width
      $error("dmem_responder: DATA_W must be 32");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  op_t               op_q;
  logic              both_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] read_data_q;
  logic              done_q, err_q, busy_q;

  logic              req_s, accept_s, stall_s;
  logic              commit_s, c_wr_s, c_both_s, c_bad_s, err_s, we_s;
  logic [31:0]       c_addr_s;
  logic [DATA_W-1:0] c_wdata_s;
  logic [29:0]       c_idx_s;
  logic [AW-1:0]     ridx_s;
  logic [DATA_W-1:0] rdata_s;

  assign req_s = mem_read | mem_write;

  // Next-state logic; the request is only looked at while IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          accept_s = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stall_s = ((state_q == IDLE) && req_s) || (state_q == WAIT);

  // With a single stall cycle the commit edge is also the accept edge, so the
  // operands come straight from the inputs instead of the latched copies.
  always_comb begin
    c_addr_s  = addr_q;
    c_wdata_s = wdata_q;
    c_wr_s    = (op_q == OP_WR);
    c_both_s  = both_q;
    if (LATENCY == 1) begin
      c_addr_s  = address;
      c_wdata_s = write_data;
      c_wr_s    = mem_write;
      c_both_s  = mem_read & mem_write;
      commit_s  = (state_q == IDLE) && req_s;
    end else begin
      commit_s  = (state_q == WAIT) && (cnt_q == '0);
    end
  end

  assign c_idx_s = c_addr_s[31:WORD_OFS];
  assign ridx_s  = c_idx_s[AW-1:0];
  assign c_bad_s = (c_addr_s[WORD_OFS-1:0] != 2'b00) || !in_range(c_idx_s, DEPTH_WORDS);
  assign err_s   = c_bad_s | c_both_s;
  assign we_s    = commit_s & c_wr_s & ~c_bad_s;

  dmem_array #(
    .DEPTH  (DEPTH_WORDS),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we_s),
    .widx  (ridx_s),
    .wdata (c_wdata_s),
    .ridx  (ridx_s),
    .rdata (rdata_s)
  );

  // Control state, request latch and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= OP_RD;
      both_q      <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= '0;
      read_data_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_s) begin
        op_q    <= mem_write ? OP_WR : OP_RD;
        both_q  <= mem_read & mem_write;
        addr_q  <= address;
        wdata_q <= write_data;
      end
      done_q <= (state_d == RESP);
      err_q  <= commit_s & err_s;
      busy_q <= (state_d != IDLE);
      // A bad address returns zero; a good read loads the word; writes leave it.
      if (commit_s) begin
        if (c_bad_s) begin
          read_data_q <= '0;
        end else if (!c_wr_s) begin
          read_data_q <= rdata_s;
        end
      end
    end
  end

  assign read_data = read_data_q;
  assign stall     = stall_s;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main plan and
// a LATENCY=1 instance for the short-latency build.
module tb_dmem_responder;

  logic        clk;
  logic        rst;

  logic        rd0, wr0;
  logic [31:0] a0, wd0;
  logic [31:0] rdat0;
  logic        st0, dn0, er0, bz0;

  logic        rd1, wr1;
  logic [31:0] a1, wd1;
  logic [31:0] rdat1;
  logic        st1, dn1, er1, bz1;

  int total;
  int bad;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .DATA_W(32)) dut0 (
    .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .address(a0),
    .write_data(wd0), .read_data(rdat0), .stall(st0), .done(dn0), .err(er0), .busy(bz0)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .DATA_W(32)) dut1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .address(a1),
    .write_data(wd1), .read_data(rdat1), .stall(st1), .done(dn1), .err(er1), .busy(bz1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (sel == 0) begin
      rd0 = rd; wr0 = wr; a0 = addr; wd0 = wd;
    end else begin
      rd1 = rd; wr1 = wr; a1 = addr; wd1 = wd;
    end
  endtask

  // One access: request held from cycle 1 through the done cycle.
  task automatic run_acc(input int sel, input string name, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd);
    int lat;
    lat = (sel == 0) ? 2 : 1;
    drive(sel, rd, wr, addr, wd);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      chk($sformatf("%s.stall.c%0d", name, c), {31'd0, (sel == 0) ? st0 : st1}, {31'd0, (c <= lat)});
      chk($sformatf("%s.done.c%0d", name, c), {31'd0, (sel == 0) ? dn0 : dn1}, {31'd0, (c == lat + 1)});
      chk($sformatf("%s.busy.c%0d", name, c), {31'd0, (sel == 0) ? bz0 : bz1}, {31'd0, (c >= 2)});
      if (c == lat + 1) begin
        chk($sformatf("%s.err", name), {31'd0, (sel == 0) ? er0 : er1}, {31'd0, exp_err});
        if (chk_rd) begin
          chk($sformatf("%s.rdata", name), (sel == 0) ? rdat0 : rdat1, exp_rd);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Drop the request and confirm nothing was re-accepted.
  task automatic idle_chk(input int sel, input string name, input logic [31:0] exp_rd);
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk({name, ".idle.stall"}, {31'd0, (sel == 0) ? st0 : st1}, 32'd0);
    chk({name, ".idle.done"},  {31'd0, (sel == 0) ? dn0 : dn1}, 32'd0);
    chk({name, ".idle.busy"},  {31'd0, (sel == 0) ? bz0 : bz1}, 32'd0);
    chk({name, ".idle.rdata"}, (sel == 0) ? rdat0 : rdat1, exp_rd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("reset.rdata", rdat0, 32'd0);
    chk("reset.done",  {31'd0, dn0}, 32'd0);
    chk("reset.err",   {31'd0, er0}, 32'd0);
    chk("reset.busy",  {31'd0, bz0}, 32'd0);
    chk("reset.stall", {31'd0, st0}, 32'd0);
    @(posedge clk);
    #1;

    run_acc(0, "wr10", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'd0);
    idle_chk(0, "wr10", 32'd0);
    run_acc(0, "wr14", 1'b0, 1'b1, 32'h0000_0014, 32'h1234_5678, 1'b0, 1'b1, 32'd0);
    idle_chk(0, "wr14", 32'd0);

    run_acc(0, "rd10", 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    idle_chk(0, "rd10", 32'hDEAD_BEEF);

    // Back-to-back reads, each request held through its RESP cycle.
    run_acc(0, "b2b_a", 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    run_acc(0, "b2b_b", 1'b1, 1'b0, 32'h0000_0014, 32'd0, 1'b0, 1'b1, 32'h1234_5678);
    idle_chk(0, "b2b", 32'h1234_5678);

    run_acc(0, "wr12_mis", 1'b0, 1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0);
    idle_chk(0, "wr12_mis", 32'd0);
    run_acc(0, "rd10_after_mis", 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    idle_chk(0, "rd10_after_mis", 32'hDEAD_BEEF);

    run_acc(0, "rd1000_oor", 1'b1, 1'b0, 32'h0000_1000, 32'd0, 1'b1, 1'b1, 32'd0);
    idle_chk(0, "rd1000_oor", 32'd0);

    run_acc(0, "rd10_pre_both", 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    run_acc(0, "both18", 1'b1, 1'b1, 32'h0000_0018, 32'h0BAD_F00D, 1'b1, 1'b1, 32'hDEAD_BEEF);
    idle_chk(0, "both18", 32'hDEAD_BEEF);
    run_acc(0, "rd18", 1'b1, 1'b0, 32'h0000_0018, 32'd0, 1'b0, 1'b1, 32'h0BAD_F00D);
    idle_chk(0, "rd18", 32'h0BAD_F00D);

    // Reset lands in the WAIT cycle of a write to 0x20.
    drive(0, 1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5);
    @(negedge clk);
    chk("midrst.stall.c1", {31'd0, st0}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.stall.wait", {31'd0, st0}, 32'd1);
    chk("midrst.busy.wait",  {31'd0, bz0}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("midrst.after.stall%0d", k), {31'd0, st0}, 32'd0);
      chk($sformatf("midrst.after.done%0d", k),  {31'd0, dn0}, 32'd0);
      chk($sformatf("midrst.after.rdata%0d", k), rdat0, 32'd0);
      @(posedge clk);
      #1;
    end
    run_acc(0, "rd20_after_rst", 1'b1, 1'b0, 32'h0000_0020, 32'd0, 1'b0, 1'b1, 32'd0);
    idle_chk(0, "rd20_after_rst", 32'd0);

    // Single-cycle latency build.
    run_acc(1, "l1_wr8", 1'b0, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 1'b0, 1'b1, 32'd0);
    idle_chk(1, "l1_wr8", 32'd0);
    run_acc(1, "l1_rd8", 1'b1, 1'b0, 32'h0000_0008, 32'd0, 1'b0, 1'b1, 32'hCAFE_F00D);
    idle_chk(1, "l1_rd8", 32'hCAFE_F00D);
    run_acc(1, "l1_rd_mis", 1'b1, 1'b0, 32'h0000_0009, 32'd0, 1'b1, 1'b1, 32'd0);
    idle_chk(1, "l1_rd_mis", 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
